// File: rtl/instr_sequencer_pkg.sv
// ISA constants and sequencer state encoding for the 4-bit core.
// Shared by the sequencer and the datapath decoder.
package core_isa_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDC = 4'h2;
    localparam logic [3:0] OP_MOV  = 4'h3;
    localparam logic [3:0] OP_LDI  = 4'h4;
    localparam logic [3:0] OP_MVR  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_MSB  = 11;
    localparam int OPC_LSB  = 8;
    localparam int FLDA_MSB = 7;
    localparam int FLDA_LSB = 4;
    localparam int FLDB_MSB = 3;
    localparam int FLDB_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT,
        S_HALT
    } seq_state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Flash fetch port and datapath control bundle between the sequencer (master)
// and the flash/datapath side (slave).
interface instr_sequencer_if #(
    parameter int AW = 9,
    parameter int IW = 12
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_data;
    logic [15:0]   dp_en;
    logic [3:0]    dp_fld_a;
    logic [3:0]    dp_fld_b;
    logic          dp_done;

    modport master (
        output imem_req, imem_addr, dp_en, dp_fld_a, dp_fld_b,
        input  imem_ack, imem_data, dp_done
    );

    modport slave (
        input  imem_req, imem_addr, dp_en, dp_fld_a, dp_fld_b,
        output imem_ack, imem_data, dp_done
    );
endinterface

// File: rtl/instr_sequencer_isa_onehot_dec.sv
// Opcode to one-hot datapath enable decoder, also reused by the datapath.
module isa_onehot_dec (
    input  logic [3:0]  opcode,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = 16'b1 << opcode;
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC, fetches from flash, pulses one-hot
// datapath enables, handles JMP/HALT and stalls on LD until the datapath reports done.
module instr_sequencer
    import core_isa_pkg::*;
#(
    parameter int            AW       = 9,
    parameter int            IW       = 12,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            FETCH_TO = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    instr_sequencer_if.master bus,
    output logic [AW-1:0]     pc,
    output logic              halted,
    output logic              fault
);

    seq_state_t    state, next_state;
    logic [IW-1:0] instr;
    logic [3:0]    to_cnt;
    logic [3:0]    opcode;
    logic [15:0]   onehot;
    logic          fetch_ack;
    logic          timeout;
    logic          req_nxt;
    logic          halted_nxt;
    logic          fault_nxt;
    logic [15:0]   dp_en_nxt;
    logic [AW-1:0] pc_nxt;

    assign opcode        = instr[OPC_MSB:OPC_LSB];
    assign fetch_ack     = (state == S_FETCH) && bus.imem_ack;
    assign timeout       = (state == S_FETCH) && !bus.imem_ack && (to_cnt == 4'(FETCH_TO - 1));
    assign bus.imem_addr = pc;

    isa_onehot_dec u_dec (
        .opcode (opcode),
        .onehot (onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (run && !fault) next_state = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ack)  next_state = S_DECODE;
                else if (timeout)  next_state = S_IDLE;
            end
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_LD:   next_state = S_WAIT;
                    OP_HALT: next_state = S_HALT;
                    default: next_state = S_FETCH;
                endcase
            end
            S_WAIT:   if (bus.dp_done) next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the enable is computed one cycle
    // early so it is visible exactly while the FSM sits in EXEC.
    always_comb begin
        req_nxt    = (next_state == S_FETCH);
        halted_nxt = (next_state == S_HALT);
        fault_nxt  = fault | timeout;
        dp_en_nxt  = '0;
        pc_nxt     = pc;
        if (state == S_DECODE && opcode != OP_JMP && opcode != OP_HALT)
            dp_en_nxt = onehot;
        if (state == S_EXEC) begin
            case (opcode)
                OP_JMP:         pc_nxt = {pc[AW-1:8], instr[FLDA_MSB:FLDB_LSB]};
                OP_LD, OP_HALT: pc_nxt = pc;
                default:        pc_nxt = pc + 1'b1;
            endcase
        end
        if (state == S_WAIT && bus.dp_done)
            pc_nxt = pc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            halted       <= 1'b0;
            fault        <= 1'b0;
            instr        <= '0;
            to_cnt       <= '0;
            bus.imem_req <= 1'b0;
            bus.dp_en    <= '0;
            bus.dp_fld_a <= '0;
            bus.dp_fld_b <= '0;
        end else begin
            pc           <= pc_nxt;
            halted       <= halted_nxt;
            fault        <= fault_nxt;
            bus.imem_req <= req_nxt;
            bus.dp_en    <= dp_en_nxt;
            to_cnt       <= (state == S_FETCH && !bus.imem_ack) ? to_cnt + 4'd1 : 4'd0;
            if (fetch_ack) begin
                instr        <= bus.imem_data;
                bus.dp_fld_a <= bus.imem_data[FLDA_MSB:FLDA_LSB];
                bus.dp_fld_b <= bus.imem_data[FLDB_MSB:FLDB_LSB];
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer: fetch/exec timing, LD stall,
// JMP and PC wrap, HALT, fetch timeout and reset during fetch.
module tb_instr_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [8:0] pc;
    logic       halted;
    logic       fault;

    int checks = 0;
    int fails  = 0;

    instr_sequencer_if #(.AW(9), .IW(12)) bus ();

    instr_sequencer #(
        .AW       (9),
        .IW       (12),
        .RESET_PC (9'd0),
        .FETCH_TO (15)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .bus    (bus),
        .pc     (pc),
        .halted (halted),
        .fault  (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        run   = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dp_done  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic pulseRun();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    // Serve one fetch with the given wait states, then sample DECODE, EXEC and the cycle after.
    task automatic applyStimulus(input string tag, input logic [11:0] word, input int waits,
                                 input logic [8:0] exp_addr, input logic [15:0] exp_en,
                                 input bit done_in_exec);
        int n = 0;
        while (!bus.imem_req && n < 40) begin
            tick();
            n++;
        end
        checkOutput({tag, "_req"}, bus.imem_req, 1);
        checkOutput({tag, "_addr"}, bus.imem_addr, exp_addr);
        repeat (waits) tick();
        bus.imem_ack  = 1'b1;
        bus.imem_data = word;
        tick();
        bus.imem_ack = 1'b0;
        checkOutput({tag, "_en_decode"}, bus.dp_en, 0);
        tick();
        if (done_in_exec) bus.dp_done = 1'b1;
        checkOutput({tag, "_en_exec"}, bus.dp_en, exp_en);
        checkOutput({tag, "_fld_a"}, bus.dp_fld_a, word[7:4]);
        checkOutput({tag, "_fld_b"}, bus.dp_fld_b, word[3:0]);
        tick();
        bus.dp_done = 1'b0;
        checkOutput({tag, "_en_after"}, bus.dp_en, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 100000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        bus.imem_data = '0;
        doReset();
        checkOutput("rst_req", bus.imem_req, 0);
        checkOutput("rst_pc", pc, 0);
        checkOutput("rst_en", bus.dp_en, 0);
        checkOutput("rst_fld_a", bus.dp_fld_a, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_fault", fault, 0);

        // Basic ADD at address 0 with zero-wait flash
        pulseRun();
        applyStimulus("add", 12'h123, 0, 9'h000, 16'h0002, 0);
        checkOutput("add_next_req", bus.imem_req, 1);
        checkOutput("add_next_addr", bus.imem_addr, 9'h001);

        // JMP to 5, then LD with dp_done during EXEC ignored and a 3-cycle stall
        applyStimulus("jmp5", 12'h705, 1, 9'h001, 16'h0000, 0);
        applyStimulus("ld", 12'h610, 0, 9'h005, 16'h0040, 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("ld_stall_req", bus.imem_req, 0);
            tick();
        end
        bus.dp_done = 1'b1;
        tick();
        bus.dp_done = 1'b0;
        checkOutput("ld_resume_req", bus.imem_req, 1);
        checkOutput("ld_resume_addr", bus.imem_addr, 9'h006);

        // Carry into PC[8], JMP within the upper page and wrap from 0x1FF
        applyStimulus("jmp_ff", 12'h7FF, 0, 9'h006, 16'h0000, 0);
        applyStimulus("nop_ff", 12'h000, 0, 9'h0FF, 16'h0001, 0);
        applyStimulus("jmp_f0", 12'h7F0, 2, 9'h100, 16'h0000, 0);
        applyStimulus("jmp_a5", 12'h7A5, 0, 9'h1F0, 16'h0000, 0);
        checkOutput("jmp_a5_pc", pc, 9'h1A5);
        applyStimulus("mov", 12'h345, 0, 9'h1A5, 16'h0008, 0);
        applyStimulus("jmp_1ff", 12'h7FF, 0, 9'h1A6, 16'h0000, 0);
        applyStimulus("nop_wrap", 12'h000, 0, 9'h1FF, 16'h0001, 0);
        checkOutput("wrap_addr", bus.imem_addr, 9'h000);

        // HALT at address 1: terminal, run ignored, cleared by reset
        applyStimulus("nop0", 12'h000, 0, 9'h000, 16'h0001, 0);
        applyStimulus("halt", 12'hF00, 0, 9'h001, 16'h0000, 0);
        checkOutput("halt_flag", halted, 1);
        checkOutput("halt_req", bus.imem_req, 0);
        checkOutput("halt_pc", pc, 9'h001);
        for (int i = 0; i < 3; i++) begin
            pulseRun();
            tick();
            checkOutput("halt_run_req", bus.imem_req, 0);
            checkOutput("halt_run_flag", halted, 1);
        end
        doReset();
        checkOutput("halt_rst_flag", halted, 0);
        checkOutput("halt_rst_pc", pc, 0);

        // Fetch timeout: request held 15 cycles, then fault
        pulseRun();
        checkOutput("to_fault_before", fault, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.imem_req) break;
            cnt++;
            tick();
        end
        checkOutput("to_req_cycles", cnt, 15);
        checkOutput("to_fault", fault, 1);
        checkOutput("to_req_drop", bus.imem_req, 0);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 12'h123;
        pulseRun();
        bus.imem_ack = 1'b0;
        tick();
        checkOutput("to_run_req", bus.imem_req, 0);
        checkOutput("to_ack_en", bus.dp_en, 0);
        checkOutput("to_sticky", fault, 1);
        doReset();
        checkOutput("to_rst_fault", fault, 0);

        // Reset during a fetch with an ack arriving in the same cycle
        pulseRun();
        applyStimulus("pre_rst", 12'h000, 0, 9'h000, 16'h0001, 0);
        checkOutput("pre_rst_addr", bus.imem_addr, 9'h001);
        repeat (2) tick();
        rst_n         = 1'b0;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 12'h123;
        tick();
        rst_n        = 1'b1;
        bus.imem_ack = 1'b0;
        checkOutput("mid_rst_req", bus.imem_req, 0);
        checkOutput("mid_rst_pc", pc, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mid_rst_en", bus.dp_en, 0);
            checkOutput("mid_rst_idle_req", bus.imem_req, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
